// File: rtl/program_loader.sv
// Packs a big-endian byte stream into instruction words and writes them to program memory
// from address 0 until HALT_WORD is written or the memory is full. LOADER_CHECKSUM_EN adds o_checksum.
module program_loader #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           BYTE_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 11,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = {DATA_WIDTH{1'b1}}
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [BYTE_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [ADDR_WIDTH:0]   o_word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] o_checksum
`endif
);

  localparam int unsigned BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned CNT_W = $clog2(BYTES) + 1;
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR  = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_en_d, busy_d, done_d, overflow_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic [ADDR_WIDTH:0]   word_count_d;
  logic                  accept;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_d;
`endif

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = o_wr_addr;
    wr_data_d    = o_wr_data;
    done_d       = o_done;
    overflow_d   = o_overflow;
    word_count_d = o_word_count;
    accept       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    checksum_d   = o_checksum;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          state_d      = StLoad;
          addr_d       = '0;
          byte_cnt_d   = '0;
          word_count_d = '0;
          done_d       = 1'b0;
          overflow_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          checksum_d   = '0;
`endif
        end
      end
      StLoad: accept = i_rx_valid;
      StWrite: begin
        if (o_wr_data == HALT_WORD) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (addr_q == MAX_ADDR) begin
          state_d    = StDone;
          done_d     = 1'b1;
          overflow_d = 1'b1;
        end else begin
          // A byte arriving in the write cycle starts the next word.
          state_d    = StLoad;
          addr_d     = addr_q + 1'b1;
          byte_cnt_d = '0;
          accept     = i_rx_valid;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      shift_d = (shift_q << BYTE_WIDTH) | DATA_WIDTH'(i_rx_data);
      if (byte_cnt_d == LAST_BYTE) begin
        state_d      = StWrite;
        byte_cnt_d   = '0;
        wr_en_d      = 1'b1;
        wr_addr_d    = addr_d;
        wr_data_d    = shift_d;
        word_count_d = o_word_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        checksum_d   = o_checksum ^ shift_d;
`endif
      end else begin
        byte_cnt_d = byte_cnt_d + 1'b1;
      end
    end

    busy_d = (state_d == StLoad) || (state_d == StWrite);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      o_checksum   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      o_wr_en      <= wr_en_d;
      o_wr_addr    <= wr_addr_d;
      o_wr_data    <= wr_data_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
      o_overflow   <= overflow_d;
      o_word_count <= word_count_d;
`ifdef LOADER_CHECKSUM_EN
      o_checksum   <= checksum_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader: a word-level model of the byte stream
// predicts the memory writes; a second instance with a 4-word memory exercises overflow.
module tb_program_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0, rst = 1'b0;
  logic        start = 1'b0, rx_valid = 1'b0, start2 = 1'b0, rx_valid2 = 1'b0;
  logic [7:0]  rx_data = '0, rx_data2 = '0;
  logic        wr_en, busy, done, overflow, wr_en2, busy2, done2, overflow2;
  logic [10:0] wr_addr;
  logic [11:0] word_count;
  logic [1:0]  wr_addr2;
  logic [2:0]  word_count2;
  logic [31:0] wr_data, wr_data2;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum, checksum2;
`endif

  program_loader dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy), .o_done(done),
    .o_overflow(overflow), .o_word_count(word_count)
`ifdef LOADER_CHECKSUM_EN
    , .o_checksum(checksum)
`endif
  );

  program_loader #(.ADDR_WIDTH(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_start(start2), .i_rx_data(rx_data2), .i_rx_valid(rx_valid2),
    .o_wr_en(wr_en2), .o_wr_addr(wr_addr2), .o_wr_data(wr_data2), .o_busy(busy2),
    .o_done(done2), .o_overflow(overflow2), .o_word_count(word_count2)
`ifdef LOADER_CHECKSUM_EN
    , .o_checksum(checksum2)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, cyc = 0, t0 = 0;
  logic [7:0]  stim[$];
  int unsigned oa[$], oa2[$], ocyc[$], exp_a[$];
  logic [31:0] od[$], od2[$], exp_d[$];
  bit          m_ovf;
  logic [31:0] m_chk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin oa.push_back(wr_addr); od.push_back(wr_data); ocyc.push_back(cyc); end
    if (wr_en2) begin oa2.push_back(wr_addr2); od2.push_back(wr_data2); end
  end

  // Expected writes straight from the byte list: words of 4 bytes, stop at HALT or full memory.
  task automatic build_model(input int depth);
    logic [31:0] w;
    exp_a.delete(); exp_d.delete(); m_ovf = 0; m_chk = '0;
    for (int i = 0; i + 3 < stim.size(); i += 4) begin
      w = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
      exp_a.push_back(exp_a.size()); exp_d.push_back(w); m_chk ^= w;
      if (w == HALT) break;
      if (exp_a.size() == depth) begin m_ovf = 1; break; end
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) stim.push_back(w[8*k +: 8]);
  endtask

  task automatic clear_obs();
    oa.delete(); od.delete(); ocyc.delete(); oa2.delete(); od2.delete();
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk); if (d == 0) start = 1; else start2 = 1;
    @(negedge clk); start = 0; start2 = 0;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input int gap);
    @(negedge clk);
    if (d == 0) begin rx_valid = 1; rx_data = b; end else begin rx_valid2 = 1; rx_data2 = b; end
    repeat (gap) begin @(negedge clk); rx_valid = 0; rx_valid2 = 0; end
  endtask

  task automatic send_range(input int d, input int lo, input int hi, input int maxgap);
    for (int i = lo; i < hi; i++) begin
      if (i == 0) t0 = cyc;
      send_byte(d, stim[i], $urandom_range(0, maxgap));
    end
    @(negedge clk); rx_valid = 0; rx_valid2 = 0;
  endtask

  task automatic wait_done(input int d, output bit ok);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (d == 0) ? done : done2;
    end
  endtask

  task automatic test_reset();
    rst = 1; #1;
    n_checks++; if ({wr_en, busy, done, overflow} !== 4'b0)
      $display("FAIL reset_flags: got %b required 0000", {wr_en, busy, done, overflow}); else n_pass++;
    n_checks++; if (wr_addr !== 11'd0 || wr_data !== 32'd0 || word_count !== 12'd0)
      $display("FAIL reset_regs: got addr=%0d data=%h count=%0d required 0", wr_addr, wr_data,
               word_count); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic();
    bit ok;
    clear_obs(); stim.delete(); push_word(32'h2400_0008); push_word(HALT); build_model(2048);
    pulse_start(0);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b required 1", busy); else n_pass++;
    send_range(0, 0, stim.size(), 2);
    wait_done(0, ok);
    n_checks++; if (!ok) $display("FAIL basic_done: got 0 required 1"); else n_pass++;
    n_checks++; if (oa.size() !== 2 || od.size() != 2) $display("FAIL basic_nwrites: got %0d required 2", oa.size());
    else begin
      n_pass++;
      n_checks++; if (oa[0] !== 0 || od[0] !== 32'h2400_0008)
        $display("FAIL basic_w0: got %0d:%h required 0:24000008", oa[0], od[0]); else n_pass++;
      n_checks++; if (oa[1] !== 1 || od[1] !== HALT)
        $display("FAIL basic_w1: got %0d:%h required 1:ffffffff", oa[1], od[1]); else n_pass++;
    end
    n_checks++; if (word_count !== 12'd2 || overflow !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_status: got count=%0d ovf=%b busy=%b required 2 0 0", word_count,
               overflow, busy); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 4; it++) begin
      clear_obs(); stim.delete();
      for (int w = 0; w < int'($urandom_range(1, 6)); w++) push_word($urandom);
      push_word(HALT); build_model(2048);
      pulse_start(0); send_range(0, 0, stim.size(), 3); wait_done(0, ok);
      n_checks++; if (!ok) $display("FAIL rand_done[%0d]: got 0 required 1", it); else n_pass++;
      n_checks++; if (oa.size() !== exp_a.size())
        $display("FAIL rand_nwrites[%0d]: got %0d required %0d", it, oa.size(), exp_a.size());
      else n_pass++;
      for (int i = 0; i < exp_a.size() && i < oa.size(); i++) begin
        n_checks++; if (oa[i] !== exp_a[i] || od[i] !== exp_d[i])
          $display("FAIL rand_write[%0d.%0d]: got %0d:%h required %0d:%h", it, i, oa[i], od[i],
                   exp_a[i], exp_d[i]); else n_pass++;
      end
      n_checks++; if (word_count !== 12'(exp_a.size()) || overflow !== 1'b0)
        $display("FAIL rand_status[%0d]: got count=%0d ovf=%b required %0d 0", it, word_count,
                 overflow, exp_a.size()); else n_pass++;
`ifdef LOADER_CHECKSUM_EN
      n_checks++; if (checksum !== m_chk)
        $display("FAIL rand_checksum[%0d]: got %h required %h", it, checksum, m_chk); else n_pass++;
`endif
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_obs(); stim.delete();
    for (int w = 0; w < 3; w++) push_word($urandom & 32'h7FFF_FFFF);
    push_word(HALT); build_model(2048);
    pulse_start(0); send_range(0, 0, stim.size(), 0); wait_done(0, ok);
    n_checks++; if (oa.size() !== 4) $display("FAIL b2b_nwrites: got %0d required 4", oa.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < oa.size(); i++) begin
      n_checks++; if (ocyc[i] - t0 !== 5 + 4 * i || od[i] !== exp_d[i] || oa[i] !== i)
        $display("FAIL b2b_write[%0d]: got cycle %0d %0d:%h required cycle %0d %0d:%h", i,
                 ocyc[i] - t0, oa[i], od[i], 5 + 4 * i, i, exp_d[i]); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_obs(); stim.delete();
    for (int w = 0; w < 5; w++) push_word($urandom & 32'h7FFF_FFFF);
    build_model(4);
    pulse_start(1); send_range(1, 0, 16, 1); wait_done(1, ok);
    send_range(1, 16, 20, 0);
    repeat (10) @(negedge clk);
    n_checks++; if (!ok || overflow2 !== 1'b1 || word_count2 !== 3'd4 || !m_ovf)
      $display("FAIL ovf_status: got done=%b ovf=%b count=%0d required 1 1 4", done2, overflow2,
               word_count2); else n_pass++;
    n_checks++; if (oa2.size() !== 4) $display("FAIL ovf_nwrites: got %0d required 4", oa2.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < oa2.size(); i++) begin
      n_checks++; if (oa2[i] !== exp_a[i] || od2[i] !== exp_d[i])
        $display("FAIL ovf_write[%0d]: got %0d:%h required %0d:%h", i, oa2[i], od2[i], exp_a[i],
                 exp_d[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_obs(); stim.delete(); push_word(32'hA5A5_0102);
    pulse_start(0); send_byte(0, stim[0], 0); send_byte(0, stim[1], 0);
    @(negedge clk); rx_valid = 0; rst = 1; #1;
    n_checks++; if ({wr_en, busy, done, overflow} !== 4'b0 || word_count !== 12'd0 || wr_data !== 32'd0)
      $display("FAIL midreset_outputs: got en/busy/done/ovf=%b count=%0d data=%h required 0",
               {wr_en, busy, done, overflow}, word_count, wr_data); else n_pass++;
    repeat (2) @(negedge clk); rst = 0;
    stim.delete(); push_word(32'h0000_0001); push_word(HALT); build_model(2048);
    pulse_start(0); send_range(0, 0, stim.size(), 1); wait_done(0, ok);
    n_checks++; if (oa.size() !== 2 || oa[0] !== 0 || od[0] !== 32'h1 || word_count !== 12'd2)
      $display("FAIL midreset_reload: got %0d writes, first %0d:%h count=%0d required 2, 0:00000001, 2",
               oa.size(), oa.size() ? oa[0] : 0, od.size() ? od[0] : 0, word_count); else n_pass++;
  endtask

  task automatic test_ignore();
    bit ok;
    rst = 1; @(negedge clk); rst = 0;
    clear_obs();
    for (int i = 0; i < 6; i++) send_byte(0, 8'($urandom), 0);
    @(negedge clk); rx_valid = 0;
    n_checks++; if (oa.size() !== 0 || busy !== 1'b0)
      $display("FAIL idle_rx_ignored: got %0d writes busy=%b required 0 0", oa.size(), busy);
    else n_pass++;
    stim.delete(); push_word($urandom); push_word($urandom); push_word(HALT); build_model(2048);
    pulse_start(0); send_range(0, 0, 6, 1);
    pulse_start(0);
    send_range(0, 6, stim.size(), 1); wait_done(0, ok);
    n_checks++; if (oa.size() !== 3 || word_count !== 12'd3)
      $display("FAIL midstart_nwrites: got %0d writes count=%0d required 3 3", oa.size(), word_count);
    else n_pass++;
    for (int i = 0; i < 3 && i < oa.size(); i++) begin
      n_checks++; if (oa[i] !== exp_a[i] || od[i] !== exp_d[i])
        $display("FAIL midstart_write[%0d]: got %0d:%h required %0d:%h", i, oa[i], od[i], exp_a[i],
                 exp_d[i]); else n_pass++;
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    clear_obs(); stim.delete(); push_word(32'h0000_000F); push_word(32'h0000_00F0); push_word(HALT);
    pulse_start(0); send_range(0, 0, stim.size(), 1); wait_done(0, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (checksum !== 32'hFFFF_FF00)
      $display("FAIL checksum: got %h required ffffff00", checksum); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_ignore();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
